// File: rtl/clk_gate_pkg.sv
`default_nettype none
// ============================================================================
// Package : clk_gate_pkg
// Purpose : Shared constants for the clock gate and its enable synchronizer.
// Rev     : 1.0  initial release
// ============================================================================
package clk_gate_pkg;

  localparam int unsigned CE_TYPE_SYNC    = 0;
  localparam int unsigned CE_TYPE_ASYNC   = 1;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage : clk_gate_pkg
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// Module  : cdc_sync_bit
// Purpose : N-stage single-bit synchronizer, async active-low reset to 0.
// Rev     : 1.0  initial release
// ============================================================================
module cdc_sync_bit
  import clk_gate_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule : cdc_sync_bit
`default_nettype wire

// File: rtl/clk_gate_bufgce.sv
`default_nettype none
// ============================================================================
// Module  : clk_gate_bufgce
// Purpose : Glitch-free latch-based clock gate with optional CE synchronizer.
// Rev     : 1.0  initial release
// ============================================================================
module clk_gate_bufgce
  import clk_gate_pkg::*;
#(
  parameter int unsigned CE_TYPE        = CE_TYPE_SYNC,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          IS_CE_INVERTED = 1'b0,
  parameter bit          IS_I_INVERTED  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic test_en,
  output logic clk_o,
  output logic en_active
);

  logic w_ci;
  logic w_ce_eff;
  logic w_en_src;
  logic w_en_gate;
  logic r_en_lat;

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $fatal(1, "clk_gate_bufgce: SYNC_STAGES must be within 2..4");
  end

  if ((CE_TYPE != CE_TYPE_SYNC) && (CE_TYPE != CE_TYPE_ASYNC)) begin : g_bad_ce_type
    $fatal(1, "clk_gate_bufgce: CE_TYPE must be 0 (SYNC) or 1 (ASYNC)");
  end

  assign w_ci     = clk ^ IS_I_INVERTED;
  assign w_ce_eff = ce ^ IS_CE_INVERTED;

  if (CE_TYPE == CE_TYPE_ASYNC) begin : g_async
    cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_ce_sync (
      .clk   (w_ci),
      .rst_n (rst_n),
      .d     (w_ce_eff),
      .q     (w_en_src)
    );
  end else begin : g_sync
    assign w_en_src = w_ce_eff;
  end

  // test_en goes straight to the latch so scan never waits on the synchronizer
  assign w_en_gate = w_en_src | test_en;

  // Transparent only while ci is low, so the AND below never sees a mid-pulse change
  always_latch begin
    if (!rst_n) begin
      r_en_lat <= 1'b0;
    end else if (!w_ci) begin
      r_en_lat <= w_en_gate;
    end
  end

  assign clk_o     = w_ci & r_en_lat;
  assign en_active = r_en_lat;

endmodule : clk_gate_bufgce
`default_nettype wire

// File: tb/tb_clk_gate_bufgce.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_gate_bufgce
// Purpose : Random-stimulus bench for six clk_gate_bufgce configurations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clk_gate_bufgce;

  localparam int NDUT = 6;
  localparam int NCYC = 400;
  localparam int HIST = NCYC + 64;

  // Per-instance configuration: bit i describes DUT i
  localparam logic [NDUT-1:0] P_ASYNC = 6'b010110;
  localparam logic [NDUT-1:0] P_CINV  = 6'b001000;
  localparam logic [NDUT-1:0] P_IINV  = 6'b110000;

  function automatic int stages_of(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  logic clk;
  logic rst_n;
  logic ce;
  logic test_en;
  logic [NDUT-1:0] clk_o_v;
  logic [NDUT-1:0] en_v;

  clk_gate_bufgce #(.CE_TYPE(0), .SYNC_STAGES(2), .IS_CE_INVERTED(1'b0), .IS_I_INVERTED(1'b0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_v[0]), .en_active(en_v[0]));
  clk_gate_bufgce #(.CE_TYPE(1), .SYNC_STAGES(2), .IS_CE_INVERTED(1'b0), .IS_I_INVERTED(1'b0))
    u_dut1 (.clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_v[1]), .en_active(en_v[1]));
  clk_gate_bufgce #(.CE_TYPE(1), .SYNC_STAGES(3), .IS_CE_INVERTED(1'b0), .IS_I_INVERTED(1'b0))
    u_dut2 (.clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_v[2]), .en_active(en_v[2]));
  clk_gate_bufgce #(.CE_TYPE(0), .SYNC_STAGES(2), .IS_CE_INVERTED(1'b1), .IS_I_INVERTED(1'b0))
    u_dut3 (.clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_v[3]), .en_active(en_v[3]));
  clk_gate_bufgce #(.CE_TYPE(1), .SYNC_STAGES(2), .IS_CE_INVERTED(1'b0), .IS_I_INVERTED(1'b1))
    u_dut4 (.clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_v[4]), .en_active(en_v[4]));
  clk_gate_bufgce #(.CE_TYPE(0), .SYNC_STAGES(2), .IS_CE_INVERTED(1'b0), .IS_I_INVERTED(1'b1))
    u_dut5 (.clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_v[5]), .en_active(en_v[5]));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b expected %0b", tag, $time, got, exp);
    end
  endtask

  // Reference model: which rising ci edges of each DUT carry a pulse.
  // Edge k pulses when, at the end of the preceding ci-low phase with rst_n high,
  // the gate enable was 1; ASYNC enables are the ce_eff sampled SYNC_STAGES
  // edges earlier, provided no reset has hit the chain since that sample.
  int kn = 0;
  int ki = 0;
  int last_rst [NDUT];
  bit pred     [NDUT];
  bit samp     [NDUT][HIST];

  task automatic model_edge(input int i, input int k);
    bit ce_eff;
    bit src;
    if (!rst_n) begin
      last_rst[i] = k;
      pred[i]     = 1'b0;
    end else begin
      ce_eff = ce ^ P_CINV[i];
      if (P_ASYNC[i])
        src = ((k - stages_of(i)) > last_rst[i]) ? samp[i][k - stages_of(i)] : 1'b0;
      else
        src = ce_eff;
      pred[i]    = src | test_en;
      samp[i][k] = ce_eff;
    end
  endtask

  always @(posedge clk) begin
    kn++;
    for (int i = 0; i < NDUT; i++)
      if (!P_IINV[i]) model_edge(i, kn);
  end

  always @(negedge clk) begin
    ki++;
    for (int i = 0; i < NDUT; i++)
      if (P_IINV[i]) model_edge(i, ki);
  end

  // clk_hi tells which clk phase we are sampling in
  task automatic check_phase(input bit clk_hi, input string ph);
    for (int i = 0; i < NDUT; i++) begin
      if (clk_hi ^ P_IINV[i]) begin
        check_bit($sformatf("clk_o[%0d]_%s", i, ph), clk_o_v[i], pred[i]);
        check_bit($sformatf("en_active[%0d]_%s", i, ph), en_v[i], pred[i]);
      end else begin
        check_bit($sformatf("clk_o_low[%0d]_%s", i, ph), clk_o_v[i], 1'b0);
      end
    end
  endtask

  bit rnd_on  = 1'b0;
  bit ce_hold = 1'b1;
  bit te_hold = 1'b0;

  task automatic reset_event();
    if (!rnd_on) return;
    if (rst_n && ($urandom_range(0, 39) == 0)) begin
      rst_n = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
        last_rst[i] = P_IINV[i] ? ki : kn;
        pred[i]     = 1'b0;
      end
    end else if (!rst_n && ($urandom_range(0, 3) == 0)) begin
      rst_n = 1'b1;
    end
  endtask

  // Intermediate values land inside one domain's high phase (glitch stress),
  // the final value before each clk edge decides that edge.
  task automatic drive_inputs(input bit decisive);
    if (!rnd_on) return;
    if (!decisive) begin
      ce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) test_en = 1'b1;
    end else begin
      if ($urandom_range(0, 3) == 0) ce_hold = ~ce_hold;
      if (te_hold) te_hold = ($urandom_range(0, 2) != 0);
      else         te_hold = ($urandom_range(0, 11) == 0);
      ce      = ce_hold;
      test_en = te_hold;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1 check_phase(1'b1, "A");
    #2 drive_inputs(1'b0);
    #2 drive_inputs(1'b1);
    #2 reset_event();
    #2 check_phase(1'b1, "B");
    #2 check_phase(1'b0, "C");
    #2 drive_inputs(1'b0);
    #2 drive_inputs(1'b1);
    #2 reset_event();
    #2 check_phase(1'b0, "D");
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      last_rst[i] = 0;
      pred[i]     = 1'b0;
    end
    rst_n   = 1'b0;
    ce      = 1'b1;
    test_en = 1'b0;
    repeat (10) run_cycle();
    rnd_on = 1'b1;
    repeat (NCYC) run_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_clk_gate_bufgce
`default_nettype wire
